// File: rtl/e42_rr.sv
// e42_rr: 4-way round-robin arbiter with a pending-event register.
// Requests in y are captured into pend when e is high. A two-state FSM
// (IDLE/HOLD) presents one granted index on a/v at a time. The grant stays
// stable until the consumer accepts it with rdy.
// Optional feature: define E42_RR_OVF_EN to build the sticky overflow flag
// (ovf). Without it, ovf is tied low and no overflow logic is built.
module e42_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic [3:0] y,
  input  logic       rdy,
  output logic [1:0] a,
  output logic       v,
  output logic [3:0] pend,
  output logic       ovf
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state, state_n;
  logic [3:0] p, p_n;
  logic [3:0] clr;
  logic [3:0] req_in;
  logic [1:0] ptr, ptr_n;
  logic [1:0] a_n;
  logic [1:0] win;
  logic       xfer;

  // A handshake can only complete while a grant is being presented.
  assign xfer = (state == HOLD) & rdy;
  assign v    = (state == HOLD);
  assign pend = p;

  // Requests only count while capture is enabled.
  assign req_in = y & {4{e}};

  // Clear the accepted grant, then OR in new events so a set beats a clear.
  always_comb begin
    clr = 4'b0000;
    if (xfer) clr = 4'b0001 << a;
    p_n = (p & ~clr) | req_in;
  end

  // Round-robin search from ptr upward. The descending loop leaves the
  // nearest set bit as the winner.
  always_comb begin
    logic [1:0] idx;
    win = ptr;
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (p[idx]) win = idx;
    end
  end

  // Next-state logic. IDLE grabs the winner; HOLD waits for the handshake.
  always_comb begin
    state_n = state;
    a_n     = a;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (p != 4'b0000) begin
          state_n = HOLD;
          a_n     = win;
        end
      end
      HOLD: begin
        if (rdy) begin
          state_n = IDLE;
          ptr_n   = a + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, grant index, pointer and pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a     <= 2'b00;
      ptr   <= 2'b00;
      p     <= 4'b0000;
    end else begin
      state <= state_n;
      a     <= a_n;
      ptr   <= ptr_n;
      p     <= p_n;
    end
  end

`ifdef E42_RR_OVF_EN
  logic [3:0] ovf_hit;

  // A repeat event counts as overflow, except on a bit being drained this edge.
  assign ovf_hit = req_in & p & ~clr;

  // The overflow flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (|ovf_hit) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_e42_rr.sv
// Directed self-checking bench for e42_rr.
module tb_e42_rr;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       e = 1'b0;
  logic [3:0] y = 4'b0000;
  logic       rdy = 1'b0;
  logic [1:0] a;
  logic       v;
  logic [3:0] pend;
  logic       ovf;

  int n_chk = 0;
  int n_err = 0;

`ifdef E42_RR_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  e42_rr dut (
    .clk(clk), .rst(rst), .e(e), .y(y), .rdy(rdy),
    .a(a), .v(v), .pend(pend), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic ev, input logic [1:0] ea,
                    input logic [3:0] ep);
    chk({tag, ".v"}, {3'b000, v}, {3'b000, ev});
    if (ev) chk({tag, ".a"}, {2'b00, a}, {2'b00, ea});
    chk({tag, ".pend"}, pend, ep);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ep;
    // Reset state
    #3;
    chk("rst.v", {3'b000, v}, 4'b0000);
    chk("rst.a", {2'b00, a}, 4'b0000);
    chk("rst.pend", pend, 4'b0000);
    chk("rst.ovf", {3'b000, ovf}, 4'b0000);
    #9 rst = 1'b0;

    // Single request, latency and transfer
    e = 1; y = 4'b0100; rdy = 1;
    step(); st("single.e1", 0, 2'd0, 4'b0100);
    e = 0; y = 0;
    step(); st("single.e2", 1, 2'd2, 4'b0100);
    step(); st("single.e3", 0, 2'd0, 4'b0000);

    // All four requests, pointer starts at zero
    do_reset();
    e = 1; y = 4'b1111; rdy = 1;
    step(); st("all.cap", 0, 2'd0, 4'b1111);
    e = 0; y = 0;
    ep = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step(); st($sformatf("all.g%0d", i), 1, 2'(i), ep);
      ep[i] = 1'b0;
      step(); st($sformatf("all.i%0d", i), 0, 2'd0, ep);
    end

    // Wrap: ptr=0, pending 1001 -> 00 then 11
    e = 1; y = 4'b1001;
    step(); st("wrap.cap", 0, 2'd0, 4'b1001);
    e = 0; y = 0;
    step(); st("wrap.g0", 1, 2'd0, 4'b1001);
    step(); st("wrap.i0", 0, 2'd0, 4'b1000);
    step(); st("wrap.g1", 1, 2'd3, 4'b1000);
    step(); st("wrap.i1", 0, 2'd0, 4'b0000);

    // Backpressure: ptr=0
    e = 1; y = 4'b0100; rdy = 0;
    step(); st("bp.cap", 0, 2'd0, 4'b0100);
    e = 0; y = 0;
    step(); st("bp.g", 1, 2'd2, 4'b0100);
    e = 1; y = 4'b0010;
    step(); st("bp.h0", 1, 2'd2, 4'b0110);
    e = 0; y = 0;
    for (int i = 1; i < 5; i++) begin
      step(); st($sformatf("bp.h%0d", i), 1, 2'd2, 4'b0110);
    end
    rdy = 1;
    step(); st("bp.x", 0, 2'd0, 4'b0010);
    step(); st("bp.g2", 1, 2'd1, 4'b0010);
    step(); st("bp.x2", 0, 2'd0, 4'b0000);

    // Set wins over clear; ptr=2
    e = 1; y = 4'b0001;
    step(); st("sc.cap", 0, 2'd0, 4'b0001);
    e = 0; y = 0;
    step(); st("sc.g", 1, 2'd0, 4'b0001);
    e = 1; y = 4'b0001;
    step(); st("sc.x", 0, 2'd0, 4'b0001);
    chk("sc.ovf", {3'b000, ovf}, 4'b0000);
    e = 0; y = 0;
    step(); st("sc.g2", 1, 2'd0, 4'b0001);
    step(); st("sc.x2", 0, 2'd0, 4'b0000);

    // Capture disabled
    e = 0; y = 4'b1111;
    step(); st("dis.0", 0, 2'd0, 4'b0000);
    step(); st("dis.1", 0, 2'd0, 4'b0000);

    // Overflow: repeat event on a pending bit
    rdy = 0; e = 1; y = 4'b0001;
    step(); st("ovf.cap", 0, 2'd0, 4'b0001);
    chk("ovf.pre", {3'b000, ovf}, 4'b0000);
    step(); st("ovf.rep", 1, 2'd0, 4'b0001);
    chk("ovf.set", {3'b000, ovf}, {3'b000, OVF_ON});
    e = 0; y = 0;
    step(); chk("ovf.hold", {3'b000, ovf}, {3'b000, OVF_ON});
    rdy = 1;
    step(); st("ovf.x", 0, 2'd0, 4'b0000);
    chk("ovf.sticky", {3'b000, ovf}, {3'b000, OVF_ON});

    // Async reset in HOLD
    rdy = 0; e = 1; y = 4'b1000;
    step(); st("ar.cap", 0, 2'd0, 4'b1000);
    e = 0; y = 0;
    step(); st("ar.g", 1, 2'd3, 4'b1000);
    #2 rst = 1;
    #1;
    chk("ar.v", {3'b000, v}, 4'b0000);
    chk("ar.a", {2'b00, a}, 4'b0000);
    chk("ar.pend", pend, 4'b0000);
    chk("ar.ovf", {3'b000, ovf}, 4'b0000);
    rst = 0;
    e = 1; y = 4'b0010;
    step(); st("ar.first", 0, 2'd0, 4'b0010);
    e = 0; y = 0;
    step(); st("ar.g2", 1, 2'd1, 4'b0010);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
